// File: rtl/bit_cpt3_pkg.sv
// ---------------------------------------------------------------------------
// bit_cpt3_pkg
// Shared constants for the 3-bit synchronous toggle counter.
//   CPT3_WIDTH : number of counter bits (one bit_cpt_stage per bit)
//   CPT3_RST   : value the counter takes on a reset edge
// ---------------------------------------------------------------------------
package bit_cpt3_pkg;

    localparam int CPT3_WIDTH = 3;
    localparam logic [CPT3_WIDTH-1:0] CPT3_RST = 3'd0;

endpackage

// File: rtl/bit_cpt_stage.sv
// ---------------------------------------------------------------------------
// bit_cpt_stage
// One bit of a synchronous toggle counter: a D flip-flop whose next value is
// q XOR t, plus the enable chain output handed to the next-higher bit.
// Ports:
//   i_clk   : clock, state updates on the rising edge only
//   i_reset : synchronous active-high reset, loads P_RST
//   i_t     : toggle enable from the previous stage (or the count enable)
//   o_q     : registered bit value
//   o_t     : toggle enable for the next stage (i_t AND q)
// ---------------------------------------------------------------------------
module bit_cpt_stage #(
    parameter logic P_RST = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_t,
    output logic o_q,
    output logic o_t
);

    logic r_q;
    logic w_next;

    // Toggle when enabled, otherwise feed the current value back.
    assign w_next = r_q ^ i_t;

    // The next bit may toggle only when this one is about to roll 1 -> 0,
    // which chains into "all lower bits are 1 and counting is enabled".
    assign o_t = i_t & r_q;

    // Single flip-flop with reset taking priority over the toggle path.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q <= P_RST;
        end else begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/bit_cpt3.sv
// ---------------------------------------------------------------------------
// bit_cpt3
// 3-bit synchronous up counter built from a chain of bit_cpt_stage toggle
// cells. All bits switch on the same clock edge; the enable chain is purely
// combinational between flip-flops, so there is no ripple clocking.
// Ports:
//   activate : count enable, active-high
//   clk      : clock, rising-edge
//   reset    : synchronous active-high reset, clears the count to 0
//   cpt      : current count, straight from the stage flip-flops
// ---------------------------------------------------------------------------
module bit_cpt3
    import bit_cpt3_pkg::*;
(
    input  logic                  activate,
    input  logic                  clk,
    input  logic                  reset,
    output logic [CPT3_WIDTH-1:0] cpt
);

    // w_tChain[i] is the toggle enable feeding stage i.
    logic [CPT3_WIDTH-1:0] w_tChain;
    logic [CPT3_WIDTH-1:0] w_q;
    logic                  w_unusedCarry;

    assign w_tChain[0] = activate;

    // Stage i passes its enable to stage i+1; the top stage's enable out
    // would only matter for a wider counter, so it is left dangling.
    for (genvar i = 0; i < CPT3_WIDTH; i++) begin : g_stage
        if (i < CPT3_WIDTH - 1) begin : g_mid
            bit_cpt_stage #(
                .P_RST (CPT3_RST[i])
            ) u_stage (
                .i_clk   (clk),
                .i_reset (reset),
                .i_t     (w_tChain[i]),
                .o_q     (w_q[i]),
                .o_t     (w_tChain[i+1])
            );
        end else begin : g_top
            bit_cpt_stage #(
                .P_RST (CPT3_RST[i])
            ) u_stage (
                .i_clk   (clk),
                .i_reset (reset),
                .i_t     (w_tChain[i]),
                .o_q     (w_q[i]),
                .o_t     (w_unusedCarry)
            );
        end
    end

    assign cpt = w_q;

endmodule

// File: tb/tb_bit_cpt3.sv
// ---------------------------------------------------------------------------
// tb_bit_cpt3
// Directed bench for bit_cpt3: start-up reset, basic counting, hold,
// wrap-around, mid-count reset and stability of cpt between rising edges.
// ---------------------------------------------------------------------------
module tb_bit_cpt3;

    logic       clk;
    logic       reset;
    logic       activate;
    logic [2:0] cpt;

    int errors = 0;
    int checks = 0;

    bit_cpt3 dut (
        .activate (activate),
        .clk      (clk),
        .reset    (reset),
        .cpt      (cpt)
    );

    // Clock starts high; rising edges fall every 40 time units.
    initial begin
        clk = 1'b1;
        forever #20 clk = ~clk;
    end

    // Set inputs, take one rising edge, then settle 5 units past it.
    task automatic applyStimulus(input logic act, input logic rst);
        activate = act;
        reset    = rst;
        @(posedge clk);
        #5;
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] expected);
        checks++;
        assert (cpt === expected) else begin
            errors++;
            $error("[TB] FAIL %s: cpt=%0d expected=%0d", tag, cpt, expected);
        end
    endtask

    initial begin
        int guard;
        activate = 1'b0;
        reset    = 1'b1;

        // Start-up reset, then reset must win over activate.
        applyStimulus(1'b0, 1'b1);
        checkOutput("startup_reset", 3'd0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("reset_priority", 3'd0);

        // Basic count 1..3.
        applyStimulus(1'b1, 1'b0);
        checkOutput("count_1", 3'd1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("count_2", 3'd2);
        applyStimulus(1'b1, 1'b0);
        checkOutput("count_3", 3'd3);

        // Hold at 3 for three edges, then resume to 4.
        applyStimulus(1'b0, 1'b0);
        checkOutput("hold_a", 3'd3);
        applyStimulus(1'b0, 1'b0);
        checkOutput("hold_b", 3'd3);
        applyStimulus(1'b0, 1'b0);
        checkOutput("hold_c", 3'd3);
        applyStimulus(1'b1, 1'b0);
        checkOutput("count_4", 3'd4);

        // Continue to 7, then wrap to 0 and 1.
        applyStimulus(1'b1, 1'b0);
        checkOutput("count_5", 3'd5);
        applyStimulus(1'b1, 1'b0);
        checkOutput("count_6", 3'd6);
        applyStimulus(1'b1, 1'b0);
        checkOutput("count_7", 3'd7);
        applyStimulus(1'b1, 1'b0);
        checkOutput("wrap_0", 3'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("wrap_1", 3'd1);

        // Count up until cpt reaches 5 with a bounded loop (4 edges needed).
        guard = 0;
        while (cpt < 3'd5 && guard < 8) begin
            applyStimulus(1'b1, 1'b0);
            guard++;
        end
        checks++;
        assert (guard === 4) else begin
            errors++;
            $error("[TB] FAIL reach_5_edges: edges=%0d expected=4", guard);
        end
        checkOutput("reach_5", 3'd5);

        // Reset mid-count with activate still high, then resume from 0.
        applyStimulus(1'b1, 1'b1);
        checkOutput("midreset_0", 3'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("after_reset_1", 3'd1);

        // Toggle inputs between edges; cpt must not move until an edge.
        activate = 1'b0;
        reset    = 1'b1;
        #3;
        checkOutput("between_a", 3'd1);
        activate = 1'b1;
        #3;
        checkOutput("between_b", 3'd1);
        reset = 1'b0;
        #3;
        checkOutput("between_c", 3'd1);
        activate = 1'b0;
        #3;
        checkOutput("between_d", 3'd1);

        // Glitches above left nothing behind: hold, then count, then reset.
        applyStimulus(1'b0, 1'b0);
        checkOutput("post_glitch_hold", 3'd1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("post_glitch_count", 3'd2);
        reset = 1'b1;
        #5;
        checkOutput("reset_before_edge", 3'd2);
        applyStimulus(1'b1, 1'b1);
        checkOutput("reset_on_edge", 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
